// File: rtl/pack_recv_if.sv
// Byte-in / word-out handshake bundle for pack_recv.
// The master modport is the environment's view; slave is the receiver's view.
interface pack_recv_if;
    logic [7:0]  DataVal;
    logic        DataReady;
    logic        DataNext;
    logic        Hunt;
    logic [15:0] OutWd;
    logic        OutValid;
    logic        OutNext;
    logic        InSync;
    logic [7:0]  SyncCount;
    logic        DataOverf;

    modport master (
        output DataVal, DataReady, Hunt, OutNext,
        input  DataNext, OutWd, OutValid, InSync, SyncCount, DataOverf
    );

    modport slave (
        input  DataVal, DataReady, Hunt, OutNext,
        output DataNext, OutWd, OutValid, InSync, SyncCount, DataOverf
    );
endinterface

// File: rtl/pack_recv.sv
// Byte-to-word packer that locks onto the FF FF FF 7F sync marker, strips
// in-stream sync pairs and queues little-endian 16-bit words in a show-ahead FIFO.
module pack_recv #(
    parameter int FIFOLOG2 = 4
) (
    input  logic        clk,
    input  logic        rst,
    pack_recv_if.slave  bus
);
    localparam int AW    = FIFOLOG2;
    localparam int PW    = FIFOLOG2 + 1;
    localparam int DEPTH = 1 << FIFOLOG2;
    localparam logic [PW:0] DEPTH_W = {1'b0, 1'b1, {AW{1'b0}}};

    typedef enum logic {ST_HUNT, ST_LOCKED} state_t;

    state_t        state_q, state_d;
    logic [1:0]    ff_cnt_q, ff_cnt_d;
    logic          pend_q, pend_d;
    logic          phase_q, phase_d;
    logic [7:0]    lo_q, lo_d;
    logic [7:0]    sync_cnt_q, sync_cnt_d;
    logic          overf_q, overf_d;
    logic          data_next_q, data_next_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [15:0]   mem_q [DEPTH];
    logic [15:0]   mem_d [DEPTH];

    logic [15:0]   word;
    logic [1:0]    nreq;
    logic [15:0]   w0, w1;
    logic [PW-1:0] count, count_d;
    logic [PW:0]   free_eff, free_d;
    logic          pop, acc0, acc1;
    logic [AW-1:0] wr_idx0, wr_idx1;

    // Sync search, word assembly and sync-pair stripping.
    always_comb begin
        state_d    = state_q;
        ff_cnt_d   = ff_cnt_q;
        pend_d     = pend_q;
        phase_d    = phase_q;
        lo_d       = lo_q;
        sync_cnt_d = sync_cnt_q;
        word       = {bus.DataVal, lo_q};
        nreq       = 2'd0;
        w0         = 16'h0000;
        w1         = 16'h0000;
        if (bus.Hunt) begin
            state_d  = ST_HUNT;
            ff_cnt_d = 2'd0;
            pend_d   = 1'b0;
            phase_d  = 1'b0;
        end else if (bus.DataReady) begin
            case (state_q)
                ST_HUNT: begin
                    if (bus.DataVal == 8'hFF) begin
                        if (ff_cnt_q != 2'd3) ff_cnt_d = ff_cnt_q + 2'd1;
                    end else if (bus.DataVal == 8'h7F && ff_cnt_q == 2'd3) begin
                        state_d    = ST_LOCKED;
                        sync_cnt_d = sync_cnt_q + 8'd1;
                        phase_d    = 1'b0;
                        ff_cnt_d   = 2'd0;
                    end else begin
                        ff_cnt_d = 2'd0;
                    end
                end
                ST_LOCKED: begin
                    if (!phase_q) begin
                        lo_d    = bus.DataVal;
                        phase_d = 1'b1;
                    end else begin
                        phase_d = 1'b0;
                        // A held FFFF is only released once we know it is not a sync pair.
                        if (pend_q) begin
                            if (word == 16'h7FFF) begin
                                pend_d     = 1'b0;
                                sync_cnt_d = sync_cnt_q + 8'd1;
                            end else if (word == 16'hFFFF) begin
                                nreq = 2'd1;
                                w0   = 16'hFFFF;
                            end else begin
                                nreq   = 2'd2;
                                w0     = 16'hFFFF;
                                w1     = word;
                                pend_d = 1'b0;
                            end
                        end else if (word == 16'hFFFF) begin
                            pend_d = 1'b1;
                        end else begin
                            nreq = 2'd1;
                            w0   = word;
                        end
                    end
                end
                default: state_d = ST_HUNT;
            endcase
        end
    end

    // FIFO write side takes up to two words; a slot freed by a same-cycle pop is reusable.
    always_comb begin
        count    = wr_ptr_q - rd_ptr_q;
        pop      = bus.OutNext && (count != '0);
        free_eff = DEPTH_W - {1'b0, count} + {{PW{1'b0}}, pop};
        acc0     = (nreq != 2'd0) && (free_eff >= (PW+1)'(1));
        acc1     = (nreq == 2'd2) && (free_eff >= (PW+1)'(2));
        overf_d  = overf_q | ((nreq != 2'd0) && !acc0) | ((nreq == 2'd2) && !acc1);
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, acc0} + {{AW{1'b0}}, acc1};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
        count_d  = wr_ptr_d - rd_ptr_d;
        free_d   = DEPTH_W - {1'b0, count_d};
        data_next_d = (free_d >= (PW+1)'(3));
        wr_idx0  = wr_ptr_q[AW-1:0];
        wr_idx1  = wr_idx0 + AW'(1);
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (acc0 && wr_idx0 == AW'(i))      mem_d[i] = w0;
            else if (acc1 && wr_idx1 == AW'(i)) mem_d[i] = w1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_HUNT;
            ff_cnt_q    <= 2'd0;
            pend_q      <= 1'b0;
            phase_q     <= 1'b0;
            lo_q        <= 8'h00;
            sync_cnt_q  <= 8'h00;
            overf_q     <= 1'b0;
            data_next_q <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 16'h0000;
        end else begin
            state_q     <= state_d;
            ff_cnt_q    <= ff_cnt_d;
            pend_q      <= pend_d;
            phase_q     <= phase_d;
            lo_q        <= lo_d;
            sync_cnt_q  <= sync_cnt_d;
            overf_q     <= overf_d;
            data_next_q <= data_next_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    assign bus.OutWd     = mem_q[rd_ptr_q[AW-1:0]];
    assign bus.OutValid  = (count != '0);
    assign bus.DataNext  = data_next_q;
    assign bus.InSync    = (state_q == ST_LOCKED);
    assign bus.SyncCount = sync_cnt_q;
    assign bus.DataOverf = overf_q;
endmodule

// File: tb/tb_pack_recv.sv
// Directed bench for pack_recv: sync lock, sync-pair stripping, pending FFFF,
// overflow, reset, hunt and simultaneous push/pop.
module tb_pack_recv;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    pack_recv_if bus();

    pack_recv #(.FIFOLOG2(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic send_byte(input logic [7:0] b);
        bus.DataVal   = b;
        bus.DataReady = 1'b1;
        @(posedge clk); #1;
        bus.DataReady = 1'b0;
    endtask

    task automatic send_word(input logic [15:0] w);
        send_byte(w[7:0]);
        send_byte(w[15:8]);
    endtask

    task automatic pop_word(output logic [15:0] w);
        w = bus.OutWd;
        bus.OutNext = 1'b1;
        @(posedge clk); #1;
        bus.OutNext = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        bus.Hunt = 1'b1; bus.DataReady = 1'b1; bus.DataVal = 8'hFF; bus.OutNext = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.InSync !== 1'b0) begin failures++; $display("FAIL rst_insync got=%b exp=0", bus.InSync); end
        checks++; if (bus.SyncCount !== 8'd0) begin failures++; $display("FAIL rst_synccount got=%0d exp=0", bus.SyncCount); end
        checks++; if (bus.OutValid !== 1'b0) begin failures++; $display("FAIL rst_outvalid got=%b exp=0", bus.OutValid); end
        checks++; if (bus.DataOverf !== 1'b0) begin failures++; $display("FAIL rst_overf got=%b exp=0", bus.DataOverf); end
        checks++; if (bus.DataNext !== 1'b0) begin failures++; $display("FAIL rst_datanext got=%b exp=0", bus.DataNext); end
        checks++; if (bus.OutWd !== 16'h0000) begin failures++; $display("FAIL rst_outwd got=%h exp=0000", bus.OutWd); end
        bus.Hunt = 1'b0; bus.DataReady = 1'b0; bus.OutNext = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (bus.DataNext !== 1'b1) begin failures++; $display("FAIL rst_release_datanext got=%b exp=1", bus.DataNext); end
        $display("test_reset done");
    endtask

    task automatic test_lock;
        logic [15:0] w;
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF);
        checks++; if (bus.InSync !== 1'b0) begin failures++; $display("FAIL lock_early got=%b exp=0", bus.InSync); end
        send_byte(8'h7F);
        checks++; if (bus.InSync !== 1'b1) begin failures++; $display("FAIL lock_insync got=%b exp=1", bus.InSync); end
        checks++; if (bus.SyncCount !== 8'd1) begin failures++; $display("FAIL lock_synccount got=%0d exp=1", bus.SyncCount); end
        checks++; if (bus.OutValid !== 1'b0) begin failures++; $display("FAIL lock_nowrite got=%b exp=0", bus.OutValid); end
        send_byte(8'h34);
        checks++; if (bus.OutValid !== 1'b0) begin failures++; $display("FAIL lock_lowbyte got=%b exp=0", bus.OutValid); end
        send_byte(8'h12);
        checks++; if (bus.OutValid !== 1'b1 || bus.OutWd !== 16'h1234) begin failures++; $display("FAIL lock_latency got=%b/%h exp=1/1234", bus.OutValid, bus.OutWd); end
        send_word(16'h5678);
        pop_word(w);
        checks++; if (w !== 16'h1234) begin failures++; $display("FAIL lock_pop0 got=%h exp=1234", w); end
        pop_word(w);
        checks++; if (w !== 16'h5678) begin failures++; $display("FAIL lock_pop1 got=%h exp=5678", w); end
        checks++; if (bus.OutValid !== 1'b0) begin failures++; $display("FAIL lock_empty got=%b exp=0", bus.OutValid); end
        $display("test_lock done");
    endtask

    task automatic test_sync_discard;
        logic [15:0] w;
        send_word(16'hFFFF);
        checks++; if (bus.OutValid !== 1'b0) begin failures++; $display("FAIL disc_held got=%b exp=0", bus.OutValid); end
        send_word(16'h7FFF);
        checks++; if (bus.OutValid !== 1'b0) begin failures++; $display("FAIL disc_pair got=%b exp=0", bus.OutValid); end
        checks++; if (bus.SyncCount !== 8'd2) begin failures++; $display("FAIL disc_synccount got=%0d exp=2", bus.SyncCount); end
        send_word(16'hABCD);
        pop_word(w);
        checks++; if (w !== 16'hABCD) begin failures++; $display("FAIL disc_word got=%h exp=abcd", w); end
        checks++; if (bus.OutValid !== 1'b0) begin failures++; $display("FAIL disc_empty got=%b exp=0", bus.OutValid); end
        $display("test_sync_discard done");
    endtask

    task automatic test_pending;
        logic [15:0] w;
        send_word(16'hFFFF);
        send_word(16'h0001);
        checks++; if (bus.OutValid !== 1'b1 || bus.OutWd !== 16'hFFFF) begin failures++; $display("FAIL pend_dual got=%b/%h exp=1/ffff", bus.OutValid, bus.OutWd); end
        pop_word(w);
        checks++; if (w !== 16'hFFFF) begin failures++; $display("FAIL pend_pop0 got=%h exp=ffff", w); end
        pop_word(w);
        checks++; if (w !== 16'h0001) begin failures++; $display("FAIL pend_pop1 got=%h exp=0001", w); end
        checks++; if (bus.OutValid !== 1'b0) begin failures++; $display("FAIL pend_empty0 got=%b exp=0", bus.OutValid); end
        send_word(16'hFFFF);
        send_word(16'hFFFF);
        checks++; if (bus.OutValid !== 1'b1 || bus.OutWd !== 16'hFFFF) begin failures++; $display("FAIL pend_ffff got=%b/%h exp=1/ffff", bus.OutValid, bus.OutWd); end
        send_word(16'h7FFF);
        checks++; if (bus.SyncCount !== 8'd3) begin failures++; $display("FAIL pend_synccount got=%0d exp=3", bus.SyncCount); end
        pop_word(w);
        checks++; if (bus.OutValid !== 1'b0 || w !== 16'hFFFF) begin failures++; $display("FAIL pend_single got=%b/%h exp=0/ffff", bus.OutValid, w); end
        $display("test_pending done");
    endtask

    task automatic test_overflow;
        logic [15:0] w;
        for (int k = 1; k <= 18; k++) begin
            send_word(16'h0100 + 16'(k));
            checks++;
            if (bus.DataNext !== (k <= 13)) begin
                failures++;
                $display("FAIL ovf_datanext word=%0d got=%b exp=%b", k, bus.DataNext, (k <= 13));
            end
            if (k == 16) begin
                checks++; if (bus.DataOverf !== 1'b0) begin failures++; $display("FAIL ovf_early got=%b exp=0", bus.DataOverf); end
            end
        end
        checks++; if (bus.DataOverf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", bus.DataOverf); end
        for (int k = 1; k <= 16; k++) begin
            pop_word(w);
            checks++;
            if (w !== 16'h0100 + 16'(k)) begin
                failures++;
                $display("FAIL ovf_pop idx=%0d got=%h exp=%h", k, w, 16'h0100 + 16'(k));
            end
        end
        checks++; if (bus.OutValid !== 1'b0) begin failures++; $display("FAIL ovf_empty got=%b exp=0", bus.OutValid); end
        checks++; if (bus.DataOverf !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", bus.DataOverf); end
        $display("test_overflow done");
    endtask

    task automatic test_rst_queued;
        for (int k = 0; k < 5; k++) send_word(16'h2000 + 16'(k));
        checks++; if (bus.OutValid !== 1'b1) begin failures++; $display("FAIL rq_queued got=%b exp=1", bus.OutValid); end
        rst = 1'b1;
        bus.OutNext = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        bus.OutNext = 1'b0;
        checks++; if (bus.OutValid !== 1'b0) begin failures++; $display("FAIL rq_outvalid got=%b exp=0", bus.OutValid); end
        checks++; if (bus.DataOverf !== 1'b0) begin failures++; $display("FAIL rq_overf got=%b exp=0", bus.DataOverf); end
        checks++; if (bus.SyncCount !== 8'd0) begin failures++; $display("FAIL rq_synccount got=%0d exp=0", bus.SyncCount); end
        checks++; if (bus.InSync !== 1'b0) begin failures++; $display("FAIL rq_insync got=%b exp=0", bus.InSync); end
        checks++; if (bus.OutWd !== 16'h0000) begin failures++; $display("FAIL rq_outwd got=%h exp=0000", bus.OutWd); end
        @(posedge clk); #1;
        $display("test_rst_queued done");
    endtask

    task automatic test_hunt;
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h7F);
        send_byte(8'h11);
        // Hunt together with an FF byte: that byte must not count toward the marker.
        bus.Hunt = 1'b1; bus.DataVal = 8'hFF; bus.DataReady = 1'b1;
        @(posedge clk); #1;
        bus.Hunt = 1'b0; bus.DataReady = 1'b0;
        checks++; if (bus.InSync !== 1'b0) begin failures++; $display("FAIL hunt_insync got=%b exp=0", bus.InSync); end
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h7F);
        checks++; if (bus.InSync !== 1'b0) begin failures++; $display("FAIL hunt_ignored_byte got=%b exp=0", bus.InSync); end
        send_byte(8'h22); send_byte(8'h33);
        checks++; if (bus.OutValid !== 1'b0) begin failures++; $display("FAIL hunt_nowrite got=%b exp=0", bus.OutValid); end
        send_byte(8'hFF); send_byte(8'hFF); send_byte(8'hFF); send_byte(8'h7F);
        checks++; if (bus.InSync !== 1'b1 || bus.SyncCount !== 8'd2) begin failures++; $display("FAIL hunt_relock got=%b/%0d exp=1/2", bus.InSync, bus.SyncCount); end
        send_word(16'h4455);
        checks++; if (bus.OutValid !== 1'b1 || bus.OutWd !== 16'h4455) begin failures++; $display("FAIL hunt_phase got=%b/%h exp=1/4455", bus.OutValid, bus.OutWd); end
        $display("test_hunt done");
    endtask

    task automatic test_back_to_back;
        logic [15:0] w;
        send_byte(8'h66);
        bus.OutNext = 1'b1;
        send_byte(8'h77);
        bus.OutNext = 1'b0;
        checks++; if (bus.OutValid !== 1'b1 || bus.OutWd !== 16'h7766) begin failures++; $display("FAIL b2b_pushpop got=%b/%h exp=1/7766", bus.OutValid, bus.OutWd); end
        pop_word(w);
        checks++; if (bus.OutValid !== 1'b0 || w !== 16'h7766) begin failures++; $display("FAIL b2b_single got=%b/%h exp=0/7766", bus.OutValid, w); end
        bus.OutNext = 1'b1;
        @(posedge clk); #1;
        bus.OutNext = 1'b0;
        checks++; if (bus.OutValid !== 1'b0) begin failures++; $display("FAIL b2b_empty_pop got=%b exp=0", bus.OutValid); end
        $display("test_back_to_back done");
    endtask

    initial begin
        bus.DataVal = 8'h00; bus.DataReady = 1'b0; bus.Hunt = 1'b0; bus.OutNext = 1'b0;
        test_reset();
        test_lock();
        test_sync_discard();
        test_pending();
        test_overflow();
        test_rst_queued();
        test_hunt();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
